// File: rtl/scene_renderer.sv
// Dino/obstacle scene renderer: 3-stage pixel pipeline over shadowed frame state.
// Optional GAME_OVER_FLASH_EN: flash dino red during game over on alternate 8-frame blocks.
module scene_renderer #(
    parameter int DINO_SCREEN_X   = 80,
    parameter int GROUND_SCREEN_Y = 400,
    parameter int DINO_CX         = 16,
    parameter int OBS_CX          = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_start,
    input  logic        pix_valid,
    input  logic [11:0] pix_x,
    input  logic [11:0] pix_y,
    input  logic [11:0] dino_y,
    input  logic [11:0] obstacle_x,
    input  logic [1:0]  dino_state,
    input  logic        night,
    input  logic        game_over,
    output logic [11:0] dino_rom_addr,
    input  logic        dino_rom_data,
    output logic [8:0]  obs_rom_addr,
    input  logic        obs_rom_data,
    output logic [11:0] rgb,
    output logic        rgb_valid
);

`ifdef GAME_OVER_FLASH_EN
    localparam bit FLASH_EN = 1'b1;
`else
    localparam bit FLASH_EN = 1'b0;
`endif

    localparam logic signed [12:0] D_LEFT = 13'(DINO_SCREEN_X - DINO_CX);
    localparam logic signed [12:0] O_TOP  = 13'(GROUND_SCREEN_Y - 32);
    localparam logic signed [12:0] O_CX   = 13'(OBS_CX);
    localparam logic [11:0]        GND_Y  = 12'(GROUND_SCREEN_Y);

    logic [11:0] dino_y_q, dino_y_d;
    logic [11:0] obs_x_q, obs_x_d;
    logic [1:0]  bank_q, bank_d;
    logic        night_q, night_d;
    logic        go_q, go_d;
    logic [3:0]  fcnt_q, fcnt_d;

    logic [11:0] d_addr_q, d_addr_d;
    logic [8:0]  o_addr_q, o_addr_d;
    logic        d_hit1_q, d_hit1_d, o_hit1_q, o_hit1_d;
    logic        gnd1_q, gnd1_d, vld1_q, vld1_d;
    logic        night1_q, night1_d, flash1_q, flash1_d;

    logic        d_hit2_q, d_hit2_d, o_hit2_q, o_hit2_d;
    logic        gnd2_q, gnd2_d, vld2_q, vld2_d;
    logic        night2_q, night2_d, flash2_q, flash2_d;

    logic [11:0] rgb_q, rgb_d;
    logic        rgb_valid_q, rgb_valid_d;

    logic signed [12:0] px, py, d_top, d_bot, o_left;
    logic [4:0]  d_row, d_col, o_row;
    logic [3:0]  o_col;
    logic        d_hit, o_hit, dino_on, obs_on;

    // Shadow registers and frame counter, loaded only at frame_start
    always_comb begin
        dino_y_d = dino_y_q;
        obs_x_d  = obs_x_q;
        bank_d   = bank_q;
        night_d  = night_q;
        go_d     = go_q;
        fcnt_d   = fcnt_q;
        if (frame_start) begin
            dino_y_d = dino_y;
            obs_x_d  = obstacle_x;
            bank_d   = dino_state;
            night_d  = night;
            go_d     = game_over;
            fcnt_d   = fcnt_q + 4'd1;
        end
    end

    // Stage 1: box tests and ROM addresses; addresses hold when not hit
    always_comb begin
        px     = $signed({1'b0, pix_x});
        py     = $signed({1'b0, pix_y});
        d_bot  = $signed({1'b0, dino_y_q});
        d_top  = d_bot - 13'sd32;
        o_left = $signed({obs_x_q[11], obs_x_q}) - O_CX;
        d_hit  = pix_valid && (px >= D_LEFT) && (px < D_LEFT + 13'sd32)
                 && (py >= d_top) && (py < d_bot);
        o_hit  = pix_valid && (px >= o_left) && (px < o_left + 13'sd16)
                 && (py >= O_TOP) && (py < O_TOP + 13'sd32);
        d_row  = pix_y[4:0] - d_top[4:0];
        d_col  = pix_x[4:0] - D_LEFT[4:0];
        o_row  = pix_y[4:0] - O_TOP[4:0];
        o_col  = pix_x[3:0] - o_left[3:0];
        d_addr_d = d_hit ? {bank_q, d_row, d_col} : d_addr_q;
        o_addr_d = o_hit ? {o_row, o_col} : o_addr_q;
        d_hit1_d = d_hit;
        o_hit1_d = o_hit;
        gnd1_d   = pix_valid && (pix_y == GND_Y);
        vld1_d   = pix_valid;
        night1_d = night_q;
        flash1_d = FLASH_EN & go_q & fcnt_q[3];
    end

    // Stage 2: delay flags to line up with ROM read data
    always_comb begin
        d_hit2_d = d_hit1_q;
        o_hit2_d = o_hit1_q;
        gnd2_d   = gnd1_q;
        vld2_d   = vld1_q;
        night2_d = night1_q;
        flash2_d = flash1_q;
    end

    // Stage 3: priority mux and palette
    always_comb begin
        dino_on     = d_hit2_q & dino_rom_data;
        obs_on      = o_hit2_q & obs_rom_data;
        rgb_valid_d = vld2_q;
        rgb_d       = 12'h000;
        if (vld2_q) begin
            if (dino_on && flash2_q)
                rgb_d = 12'hF00;
            else if (dino_on || obs_on || gnd2_q)
                rgb_d = night2_q ? 12'hAAA : 12'h555;
            else
                rgb_d = night2_q ? 12'h000 : 12'hFFF;
        end
    end

    // All state registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dino_y_q <= '0; obs_x_q <= '0; bank_q <= '0;
            night_q <= 1'b0; go_q <= 1'b0; fcnt_q <= '0;
            d_addr_q <= '0; o_addr_q <= '0;
            d_hit1_q <= 1'b0; o_hit1_q <= 1'b0; gnd1_q <= 1'b0;
            vld1_q <= 1'b0; night1_q <= 1'b0; flash1_q <= 1'b0;
            d_hit2_q <= 1'b0; o_hit2_q <= 1'b0; gnd2_q <= 1'b0;
            vld2_q <= 1'b0; night2_q <= 1'b0; flash2_q <= 1'b0;
            rgb_q <= '0; rgb_valid_q <= 1'b0;
        end else begin
            dino_y_q <= dino_y_d; obs_x_q <= obs_x_d; bank_q <= bank_d;
            night_q <= night_d; go_q <= go_d; fcnt_q <= fcnt_d;
            d_addr_q <= d_addr_d; o_addr_q <= o_addr_d;
            d_hit1_q <= d_hit1_d; o_hit1_q <= o_hit1_d; gnd1_q <= gnd1_d;
            vld1_q <= vld1_d; night1_q <= night1_d; flash1_q <= flash1_d;
            d_hit2_q <= d_hit2_d; o_hit2_q <= o_hit2_d; gnd2_q <= gnd2_d;
            vld2_q <= vld2_d; night2_q <= night2_d; flash2_q <= flash2_d;
            rgb_q <= rgb_d; rgb_valid_q <= rgb_valid_d;
        end
    end

    assign dino_rom_addr = d_addr_q;
    assign obs_rom_addr  = o_addr_q;
    assign rgb           = rgb_q;
    assign rgb_valid     = rgb_valid_q;

endmodule

// File: tb/tb_scene_renderer.sv
// Scoreboard bench for scene_renderer: directed pixels, decoupled monitor.
// Honours GAME_OVER_FLASH_EN for the flash expectations.
module tb_scene_renderer;

`ifdef GAME_OVER_FLASH_EN
    localparam bit FL = 1'b1;
`else
    localparam bit FL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        frame_start, pix_valid, night, game_over;
    logic [11:0] pix_x, pix_y, dino_y, obstacle_x;
    logic [1:0]  dino_state;
    logic [11:0] dino_rom_addr;
    logic        dino_rom_data;
    logic [8:0]  obs_rom_addr;
    logic        obs_rom_data;
    logic [11:0] rgb;
    logic        rgb_valid;

    typedef struct {
        logic [11:0] rgb;
        int          cyc;
        string       name;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   nfs = 0;

    scene_renderer dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
        .dino_y(dino_y), .obstacle_x(obstacle_x),
        .dino_state(dino_state), .night(night), .game_over(game_over),
        .dino_rom_addr(dino_rom_addr), .dino_rom_data(dino_rom_data),
        .obs_rom_addr(obs_rom_addr), .obs_rom_data(obs_rom_data),
        .rgb(rgb), .rgb_valid(rgb_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ROM models: dino set in columns 0-15, obstacle set except column 15
    always @(posedge clk) begin
        dino_rom_data <= (dino_rom_addr[4:0] < 5'd16);
        obs_rom_data  <= (obs_rom_addr[3:0] != 4'hF);
    end

    always @(negedge clk) begin
        if (rst_n) begin
            n_chk++;
            if (rgb_valid) begin
                if (sbq.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_pixel: rgb=%h with empty scoreboard", rgb);
                end else begin
                    mon_e = sbq.pop_front();
                    if (rgb !== mon_e.rgb || cyc - mon_e.cyc != 3) begin
                        n_fail++;
                        $display("FAIL %s: rgb=%h lat=%0d, expected rgb=%h lat=3",
                                 mon_e.name, rgb, cyc - mon_e.cyc, mon_e.rgb);
                    end
                end
            end else if (rgb !== 12'h000) begin
                n_fail++;
                $display("FAIL idle_rgb: rgb=%h, expected 000", rgb);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic frame(input logic [11:0] dy, input logic [11:0] ox,
                         input logic [1:0] st, input logic nt, input logic go);
        dino_y = dy; obstacle_x = ox; dino_state = st;
        night = nt; game_over = go;
        frame_start = 1'b1; pix_valid = 1'b0;
        nfs++;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic pix(input logic [11:0] x, input logic [11:0] y,
                       input logic [11:0] e, input string nm);
        exp_t t;
        pix_valid = 1'b1; pix_x = x; pix_y = y;
        t.rgb = e; t.cyc = cyc; t.name = nm;
        sbq.push_back(t);
        tick();
        pix_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        pix_valid = 1'b0;
        repeat (n) tick();
    endtask

    initial begin
        rst_n = 1'b0; frame_start = 1'b0; pix_valid = 1'b0;
        pix_x = '0; pix_y = '0; dino_y = '0; obstacle_x = '0;
        dino_state = '0; night = 1'b0; game_over = 1'b0;
        repeat (2) tick();
        chk("rst_rgb", rgb, 12'h000);
        chk("rst_rgb_valid", rgb_valid, 1'b0);
        chk("rst_dino_addr", dino_rom_addr, 12'h000);
        chk("rst_obs_addr", obs_rom_addr, 9'h000);
        rst_n = 1'b1;
        tick();

        dino_y = 12'd400; obstacle_x = 12'd300;
        pix(12'd64, 12'd368, 12'hFFF, "pre_frame_shadow");
        pix(12'd10, 12'd10, 12'hFFF, "rst_bg");

        frame(12'd400, 12'd300, 2'd2, 1'b0, 1'b0);
        pix(12'd10, 12'd10, 12'hFFF, "day_bg");
        pix(12'd200, 12'd400, 12'h555, "day_ground");
        pix(12'd64, 12'd368, 12'h555, "dino_origin");
        chk("dino_addr_origin", dino_rom_addr, 12'h800);
        pix(12'd95, 12'd399, 12'hFFF, "dino_corner");
        chk("dino_addr_corner", dino_rom_addr, 12'hBFF);
        idle(2);
        pix(12'd300, 12'd380, 12'h555, "obs_hit");
        chk("obs_addr_hit", obs_rom_addr, 9'h0C8);
        chk("dino_addr_hold", dino_rom_addr, 12'hBFF);
        pix(12'd307, 12'd399, 12'hFFF, "obs_corner");
        chk("obs_addr_corner", obs_rom_addr, 9'h1FF);
        idle(1);

        frame(12'd400, 12'd300, 2'd0, 1'b1, 1'b0);
        pix(12'd200, 12'd400, 12'hAAA, "night_ground");
        pix(12'd200, 12'd401, 12'h000, "night_bg");
        pix(12'd64, 12'd368, 12'hAAA, "night_dino");

        frame(12'd400, 12'hFFC, 2'd0, 1'b0, 1'b0);
        pix(12'd0, 12'd380, 12'h555, "obs_neg_partial");
        chk("obs_addr_neg", obs_rom_addr, 9'h0CC);
        frame(12'd400, 12'hFEC, 2'd0, 1'b0, 1'b0);
        pix(12'd0, 12'd380, 12'hFFF, "obs_offscreen");
        chk("obs_addr_off_hold", obs_rom_addr, 9'h0CC);

        frame(12'd400, 12'd300, 2'd0, 1'b0, 1'b0);
        pix(12'd64, 12'd368, 12'h555, "tear_a");
        dino_y = 12'd300;
        pix(12'd64, 12'd368, 12'h555, "tear_b");
        pix(12'd64, 12'd270, 12'hFFF, "tear_c");
        frame_start = 1'b1;
        nfs++;
        pix(12'd64, 12'd270, 12'hFFF, "fs_coincident");
        frame_start = 1'b0;
        pix(12'd64, 12'd270, 12'h555, "after_fs");
        pix(12'd64, 12'd368, 12'hFFF, "old_box_gone");
        idle(1);

        for (int f = 0; f < 16; f++) begin
            frame(12'd400, 12'd80, 2'd0, 1'b0, 1'b1);
            pix(12'd72, 12'd370,
                (FL && (nfs % 16) >= 8) ? 12'hF00 : 12'h555, "flash_dino");
            if (f == 0) begin
                chk("prio_dino_addr", dino_rom_addr, 12'h048);
                chk("prio_obs_addr", obs_rom_addr, 9'h020);
            end
            pix(12'd82, 12'd370, 12'h555, "flash_obs_only");
        end
        idle(4);

        frame(12'd400, 12'd300, 2'd0, 1'b1, 1'b0);
        repeat (4) pix(12'd10, 12'd10, 12'h000, "pre_rst_px");
        chk("pre_rst_valid", rgb_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_rgb", rgb, 12'h000);
        chk("midrst_valid", rgb_valid, 1'b0);
        chk("midrst_dino_addr", dino_rom_addr, 12'h000);
        sbq.delete();
        nfs = 0;
        tick();
        tick();
        rst_n = 1'b1;
        pix(12'd200, 12'd400, 12'h555, "post_rst_day");
        pix(12'd64, 12'd368, 12'hFFF, "post_rst_shadow0");

        for (int i = 0; i < 20 && sbq.size() != 0; i++) tick();
        if (sbq.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: %0d pixels outstanding, expected 0", sbq.size());
        end
        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/scene_renderer.md
SCENE_RENDERER -- requirements
Module: scene_renderer

Interface
REQ-001 Parameters (name, default, meaning): DINO_SCREEN_X, 80, dino sprite centre column; GROUND_SCREEN_Y, 400, ground row and dino foot row; DINO_CX, 16, dino column offset of the sprite centre; OBS_CX, 8, obstacle column offset of the sprite centre.
REQ-002 Fixed sprite sizes: dino 32x32, obstacle 16x32, 1 bit per pixel.
REQ-003 Ports (name, direction, width, meaning):
- clk, in, 1, pixel clock.
- rst_n, in, 1, reset; one clock; reset is asynchronous and active-low.
- frame_start, in, 1, one-cycle pulse at the start of vertical blanking.
- pix_valid, in, 1, active-video pixel present.
- pix_x, in, 12, pixel column.
- pix_y, in, 12, pixel row.
- dino_y, in, 12, dino foot row from game logic.
- obstacle_x, in, 12 signed, obstacle centre column.
- dino_state, in, 2, sprite bank select.
- night, in, 1, night palette.
- game_over, in, 1, game ended.
- dino_rom_addr, out, 12, {bank, row[4:0], col[4:0]}.
- dino_rom_data, in, 1, dino ROM output, 1-cycle read latency.
- obs_rom_addr, out, 9, {row[4:0], col[3:0]}.
- obs_rom_data, in, 1, obstacle ROM output, 1-cycle read latency.
- rgb, out, 12, 4:4:4 pixel colour.
- rgb_valid, out, 1, rgb is an active pixel.

Function
REQ-004 On frame_start, latch dino_y, obstacle_x, dino_state, night and game_over into shadow registers. All rendering uses the shadow values only, so no frame ever tears.
REQ-005 A frame_start coincident with pix_valid affects pixels presented from the next cycle onward.
REQ-006 Pipeline stage 1 computes the hit flags and ROM addresses, and drives both ROM addresses registered.
REQ-007 Stage 2 captures the ROM data together with the delayed hit flags and pix_valid.
REQ-008 Stage 3 registers rgb and rgb_valid. Latency from pix_valid/pix_x/pix_y to rgb/rgb_valid is exactly 3 cycles.
REQ-009 The pipeline accepts one pixel per cycle, has no stall, and gaps in pix_valid propagate as rgb_valid=0.
REQ-010 Dino box:
- left = DINO_SCREEN_X - DINO_CX, top = dino_y - 32.
- Hit when left <= pix_x < left+32 and top <= pix_y < dino_y.
- Arithmetic is 13-bit signed; a negative top is clipped naturally.
REQ-011 Obstacle box:
- left = obstacle_x - OBS_CX, top = GROUND_SCREEN_Y - 32.
- Hit when left <= pix_x < left+16 and top <= pix_y < GROUND_SCREEN_Y.
- Comparisons are signed 13-bit; a negative obstacle_x gives partial visibility at the left edge, and a box fully off-screen gives no hit.
REQ-012 ROM row and col are pix minus box origin. Addresses for non-hit pixels are don't-care but SHALL remain stable at their last value.
REQ-013 Priority: dino (hit and rom bit 1) > obstacle (hit and rom bit 1) > ground (pix_y == GROUND_SCREEN_Y) > background.
REQ-014 Day palette: background 12'hFFF, foreground/ground 12'h555.
REQ-015 Night palette (shadow night=1): background 12'h000, foreground/ground 12'hAAA.
REQ-016 When rgb_valid=0, rgb SHALL be 12'h000.
REQ-017 A 4-bit frame counter increments on every frame_start and wraps 15 to 0.

Reset
REQ-018 While rst_n=0, the following SHALL be 0:
- all shadow registers and the frame counter;
- all pipeline registers;
- dino_rom_addr, obs_rom_addr, rgb, rgb_valid.
REQ-019 Reset asserted mid-frame SHALL clear the outputs asynchronously.
REQ-020 After release, rgb_valid rises no earlier than 3 cycles after the first pix_valid. Shadow values stay at 0 until the first frame_start.

Configuration
REQ-021 Macro GAME_OVER_FLASH_EN defined: while shadow game_over=1 and frame counter bit 3 = 1, dino foreground pixels are 12'hF00. All other colours are unchanged.
REQ-022 GAME_OVER_FLASH_EN undefined: game_over is latched but has no effect on the output, and the frame counter may be optimised away.

Verification
REQ-023 Day palette, no sprite hit:
- Stimulus: pix_valid=1, (10,10), shadow day.
- Response: rgb=12'hFFF, rgb_valid=1 exactly 3 cycles later.
REQ-024 Ground line at night:
- Stimulus: night=1 latched at frame_start, pixel (200,400).
- Response: rgb=12'hAAA; pixel (200,401) gives 12'h000.
REQ-025 Dino box origin and priority:
- Stimulus: dino_y=400, dino_state=2, pixel (64,368).
- Response: dino_rom_addr=12'h800.
- Stimulus: ROM returns 1 while the obstacle also hits.
- Response: dino foreground colour wins.
REQ-026 Negative obstacle position:
- Stimulus: obstacle_x=-4, pixel (0,380).
- Response: obs_rom_addr={5'd12,4'd12} and a hit.
- Stimulus: obstacle_x=-20.
- Response: no hit.
REQ-027 No mid-frame tearing:
- Stimulus: change dino_y mid-frame with no frame_start.
- Response: output is unchanged until the pixels after the next frame_start.
REQ-028 Game-over flash, reset mid-frame:
- Stimulus (macro defined): game_over=1 over 16 frames.
- Response: dino foreground is 12'hF00 in frames 8-15 only.
- Stimulus: rst_n pulsed mid-line.
- Response: rgb=0 and rgb_valid=0 immediately.
